// File: rtl/key_input_pkg.sv
// Shared types for the key input bank: event-select mode and auto-repeat FSM states.
package key_input_pkg;

  typedef enum logic [1:0] {
    MODE_PRESS,
    MODE_RELEASE,
    MODE_BOTH
  } key_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

endpackage

// File: rtl/key_channel.sv
// One key channel: two-flop synchroniser, debounce counter, edge select and
// optional auto-repeat. pulse_nxt is exposed so the bank can register any_pulse alongside pulse.
module key_channel
  import key_input_pkg::*;
#(
  parameter bit        ACTIVE_LOW      = 1'b0,
  parameter int        DEBOUNCE_CYCLES = 4,
  parameter key_mode_t EDGE_MODE       = MODE_RELEASE,
  parameter bit        REPEAT_EN       = 1'b0,
  parameter int        REPEAT_DELAY    = 16,
  parameter int        REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic en,
  output logic level,
  output logic pulse,
  output logic pulse_nxt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          sync1, sync2;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt;
  logic          rise, fall, edge_evt, rep_fire;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a value (no latch).
  always_comb begin
    level_nxt = level;
    cnt_nxt   = '0;
    if (sync2 != level) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) level_nxt = sync2;
      else                                 cnt_nxt   = cnt + 1'b1;
    end
  end

  assign rise      = level_nxt & ~level;
  assign fall      = ~level_nxt & level;
  assign edge_evt  = (rise & (EDGE_MODE != MODE_RELEASE)) |
                     (fall & (EDGE_MODE != MODE_PRESS));
  assign pulse_nxt = en & (edge_evt | rep_fire);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= key ^ ACTIVE_LOW;
      sync2 <= sync1;
      level <= level_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
    end
  end

  if (REPEAT_EN && (EDGE_MODE != MODE_RELEASE)) begin : g_rep
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;

    rep_state_t    state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
      end
    end

    // Looking at level_nxt lets a release win over a repeat falling on the same edge.
    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      rep_fire  = 1'b0;
      if (!level_nxt) begin
        state_nxt = IDLE;
        rcnt_nxt  = '0;
      end else begin
        unique case (state)
          IDLE: if (rise) begin
            state_nxt = DELAY;
            rcnt_nxt  = '0;
          end
          DELAY: if (rcnt == RW'(REPEAT_DELAY - 1)) begin
            rep_fire  = 1'b1;
            rcnt_nxt  = '0;
            state_nxt = REPEAT;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
          REPEAT: if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
            rep_fire = 1'b1;
            rcnt_nxt = '0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
          default: begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
          end
        endcase
      end
    end
  end else begin : g_norep
    assign rep_fire = 1'b0;
  end

endmodule

// File: rtl/key_input_bank.sv
// N_KEYS independent debounced key channels feeding the game-control FSM with
// a level vector, a one-cycle pulse vector and a registered any_pulse.
module key_input_bank
  import key_input_pkg::*;
#(
  parameter int        N_KEYS          = 4,
  parameter bit        ACTIVE_LOW      = 1'b0,
  parameter int        DEBOUNCE_CYCLES = 4,
  parameter key_mode_t EDGE_MODE       = MODE_RELEASE,
  parameter bit        REPEAT_EN       = 1'b0,
  parameter int        REPEAT_DELAY    = 16,
  parameter int        REPEAT_PERIOD   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  input  logic              en,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] pulse,
  output logic              any_pulse
);

  logic [N_KEYS-1:0] pulse_nxt;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_MODE       (EDGE_MODE),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .key       (key[i]),
      .en        (en),
      .level     (level[i]),
      .pulse     (pulse[i]),
      .pulse_nxt (pulse_nxt[i])
    );
  end

  // Built from the channels' next-pulse terms so any_pulse rises on the same edge as pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_pulse <= 1'b0;
    else     any_pulse <= |pulse_nxt;
  end

endmodule
